// File: rtl/rv32i_types.sv
// Shared types for the RV32I out-of-order core: decoded instruction info,
// ROB commit-bus entries and the flush descriptor.
package rv32i_types;

  localparam int unsigned XLen    = 32;
  localparam int unsigned RobSize = 8;
  localparam int unsigned RobTagW = $clog2(RobSize);

  typedef logic [RobTagW-1:0] rob_tag_t;

  typedef enum logic [6:0] {
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpBranch = 7'b1100011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011,
    OpImm    = 7'b0010011,
    OpReg    = 7'b0110011
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] imm;
  } pci_t;

  typedef struct packed {
    logic [XLen-1:0] data;
    logic            rdy;
    pci_t            pc_info;
  } sal2_t;

  typedef struct packed {
    rob_tag_t front_tag;
    logic     valid;
  } flush_t;

endpackage

// File: rtl/rob_commit_select.sv
// Retire selection: longest run of valid && done entries starting at the
// head, capped by max_commit and by a caller-supplied limit.
module rob_commit_select
  import rv32i_types::*;
#(
  parameter int unsigned size       = 8,
  parameter int unsigned max_commit = 2
) (
  input  logic [size-1:0]              valid,
  input  logic [size-1:0]              done,
  input  logic [$clog2(size)-1:0]      front,
  input  logic [$clog2(size+1)-1:0]    limit,
  output logic [size-1:0]              mask,
  output logic [$clog2(size+1)-1:0]    n
);

  localparam int unsigned TagW = $clog2(size);
  localparam int unsigned CntW = $clog2(size + 1);

  logic            run;
  logic [TagW-1:0] idx;

  always_comb begin
    mask = '0;
    n    = '0;
    run  = 1'b1;
    idx  = '0;
    for (int unsigned k = 0; k < max_commit; k++) begin
      idx = front + TagW'(k);
      if (run && (CntW'(k) < limit) && valid[idx] && done[idx]) begin
        mask[idx] = 1'b1;
        n         = n + CntW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates at rear, captures CDB results, retires
// up to max_commit done entries from the head, and squashes on mispredict.
module rob_commit
  import rv32i_types::*;
#(
  parameter int unsigned width      = 32,
  parameter int unsigned size       = 8,
  parameter int unsigned max_commit = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid,
  input  pci_t                    enq_pc_info,
  output logic                    enq_ready,
  output logic [$clog2(size)-1:0] enq_tag,
  input  logic                    cdb_valid,
  input  logic [$clog2(size)-1:0] cdb_tag,
  input  logic [width-1:0]        cdb_data,
  input  logic                    br_mispredict,
  input  logic [$clog2(size)-1:0] br_tag,
  output logic                    commit,
  output sal2_t [size-1:0]        rdest,
  output logic [size-1:0][4:0]    rd_bus,
  output flush_t                  flush,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned TagW = $clog2(size);
  localparam int unsigned CntW = $clog2(size + 1);

  typedef logic [TagW-1:0] tag_t;
  typedef logic [CntW-1:0] cnt_t;

  tag_t              front_q, front_d, rear_q, rear_d;
  cnt_t              count_q, count_d;
  logic [size-1:0]   valid_q, valid_d, done_q, done_d;
  logic [width-1:0]  data_q [size];
  pci_t              pci_q  [size];

  logic              commit_q;
  sal2_t [size-1:0]  rdest_q;
  flush_t            flush_q;

  logic              enq_fire, br_hit;
  tag_t              br_dist, off;
  cnt_t              limit, n;
  logic [size-1:0]   retire;

  assign full      = (count_q == cnt_t'(size));
  assign empty     = (count_q == '0);
  // rst doubles as a data term so dispatch sees no free slot while in reset.
  assign enq_ready = rst && !full && !br_mispredict;
  assign enq_tag   = rear_q;
  assign enq_fire  = enq_valid && enq_ready;

  assign br_hit  = br_mispredict && valid_q[br_tag];
  assign br_dist = br_tag - front_q;
  // On a mispredict nothing younger than br_tag may retire.
  assign limit   = br_hit ? (cnt_t'(br_dist) + cnt_t'(1)) : count_q;

  rob_commit_select #(
    .size       (size),
    .max_commit (max_commit)
  ) u_select (
    .valid (valid_q),
    .done  (done_q),
    .front (front_q),
    .limit (limit),
    .mask  (retire),
    .n     (n)
  );

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    front_d = front_q + n[TagW-1:0];
    rear_d  = rear_q;
    count_d = count_q;
    off     = '0;

    if (cdb_valid && valid_q[cdb_tag]) done_d[cdb_tag] = 1'b1;
    valid_d = valid_d & ~retire;
    done_d  = done_d & ~retire;

    if (br_hit) begin
      for (int i = 0; i < size; i++) begin
        off = tag_t'(i) - front_q;
        if (off > br_dist) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      rear_d  = br_tag + tag_t'(1);
      count_d = limit - n;
    end else begin
      if (enq_fire) begin
        valid_d[rear_q] = 1'b1;
        done_d[rear_q]  = 1'b0;
        rear_d          = rear_q + tag_t'(1);
      end
      count_d = count_q + cnt_t'(enq_fire) - n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_q  <= '0;
      rear_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      commit_q <= 1'b0;
      rdest_q  <= '0;
      flush_q  <= '0;
      for (int i = 0; i < size; i++) begin
        data_q[i] <= '0;
        pci_q[i]  <= '0;
      end
    end else begin
      front_q  <= front_d;
      rear_q   <= rear_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      if (cdb_valid && valid_q[cdb_tag]) data_q[cdb_tag] <= cdb_data;
      if (enq_fire) pci_q[rear_q] <= enq_pc_info;
      commit_q          <= |retire;
      flush_q.front_tag <= front_q;
      flush_q.valid     <= br_hit;
      for (int i = 0; i < size; i++) begin
        rdest_q[i].data    <= data_q[i];
        rdest_q[i].rdy     <= retire[i];
        rdest_q[i].pc_info <= pci_q[i];
      end
    end
  end

  assign commit = commit_q;
  assign rdest  = rdest_q;
  assign flush  = flush_q;

  always_comb begin
    for (int i = 0; i < size; i++) rd_bus[i] = rdest_q[i].pc_info.rd;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order reorder buffer and commit stage of the out-of-order RV32I core.
- Allocates one entry per dispatched instruction and captures results from the common data bus (CDB).
- Retires consecutive ready head entries in program order.
- Drives the commit/rdest/rd_bus/flush interface consumed by the commit-checking software model and the architectural register file.

Parameters:
- width, 32, data width of results
- size, 8, number of ROB entries (power of two)
- max_commit, 2, maximum entries retired per cycle (1..size)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- enq_valid  input  1  dispatch requests an entry
- enq_pc_info  input  pci_t  decoded instruction info (opcode, rd, rs1, rs2, pc, imms)
- enq_ready  output  1  entry available (not full, no flush this cycle)
- enq_tag  output  $clog2(size)  tag given to the dispatching instruction (= rear)
- cdb_valid  input  1  result broadcast valid
- cdb_tag  input  $clog2(size)  ROB tag of the result
- cdb_data  input  width  result value
- br_mispredict  input  1  resolved branch/jalr mispredicted
- br_tag  input  $clog2(size)  tag of the mispredicted instruction
- commit  output  1  at least one entry retires this cycle
- rdest  output  sal2_t[size]  entry array; .rdy high only on entries retiring this cycle
- rd_bus  output  5[size]  destination register per entry
- flush  output  flush_t  .front_tag = head index for the current commit group; .valid = flush occurred
- empty  output  1  count == 0
- full  output  1  count == size

Behaviour:
- Storage: circular array; registered front, rear, count; per-entry valid, done, data, pc_info.
- Reset (rst low, async): all entries invalid, front=rear=count=0, empty=1, full=0, commit=0, rdest all-zero, flush='0, enq_ready=0 during reset and 1 after.
- enq_ready = !full && !br_mispredict.
- Enqueue: when enq_valid && enq_ready, entry[rear] becomes valid with done=0; rear increments mod size.
- Writeback: when cdb_valid and entry[cdb_tag] is valid, set data and done=1 at the clock edge. Writeback to an invalid entry is ignored.
- Commit (combinational select, registered outputs):
  - Retire the longest run from front of valid && done entries, capped at max_commit.
  - Outputs are registered one cycle later: commit=1, and rdest[i].rdy=1 for exactly the retired indices.
  - flush.front_tag = front value before advance; retired entries are invalidated; front += n mod size.
  - commit is 0 in any cycle with no retirement.
- A result written back in cycle t is eligible for commit no earlier than cycle t+1; the outputs appear at edge t+2.
- Flush on br_mispredict:
  - All entries strictly younger than br_tag (br_tag+1 .. rear-1, with wrap) are invalidated.
  - rear = br_tag+1 mod size; count is recomputed.
  - Enqueue is dropped that cycle.
  - Entries at or older than br_tag still commit normally that cycle.
  - flush.valid pulses for one cycle.
  - A mispredict whose br_tag is invalid is ignored.
- Simultaneous enqueue and commit: count += enq - n. A full ROB may not enqueue even if a commit is happening in the same cycle, because full is registered.
- Wrap-around: all index arithmetic is mod size; front == rear is disambiguated by count.
- Reset mid-operation discards all in-flight entries immediately. No commit pulse may follow reset.

Decomposition:
- Shared package rv32i_types holds:
  - pci_t, sal2_t (data, rdy, pc_info), flush_t (front_tag, valid)
  - the opcode enum
  - rob_tag_t = logic [$clog2(size)-1:0]
- One natural sub-module, rob_commit_select: combinational priority scan from front producing the retire mask and count n.

Test Plan:
- Reset release, then enqueue 3 addi, CDB tags 0,1,2 with 5, 6, 7 in one cycle each. Required: commit pulses retiring tags {0,1} (front_tag=0), then {2} (front_tag=2); rdest[0].data=5; empty=1 afterwards.
- Out-of-order CDB: tag 1 written first, tag 0 written two cycles later. Required: no commit until tag 0 is done, then tags 0 and 1 retire together.
- Fill 8 entries. Required: full=1, enq_ready=0, a 9th enq_valid is ignored, enq_tag stays 0 until the head commits.
- Wrap case: front=6 and rear=2 (4 entries), br_mispredict with br_tag=7. Required: entries 0 and 1 invalidated, rear=0, count=2, flush.valid for 1 cycle; a CDB to tag 1 the next cycle is ignored.
- Mispredict in the same cycle as enq_valid and as commit of tag 3 (br_tag=4). Required: enqueue dropped, tag 3 still committed, rear=5.
- Assert rst low while 5 entries are in flight and two are done. Required: outputs go to reset values immediately; no commit pulse for 3 cycles after rst returns high.
